// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, MEMWAIT, ERR} state_t;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  function automatic logic reg_match(input logic we, input logic [3:0] a, input logic [3:0] r);
    return we && (a == r);
  endfunction
endpackage

// File: rtl/pipe_fwd_sel.sv
// pipe_fwd_sel: forwarding select for one EX operand, MEM result beats WB result
module pipe_fwd_sel
  import pipe_ctrl_pkg::*;
(
  input  logic [3:0] rs_e,
  input  logic [3:0] a3_m,
  input  logic       rf_we_m,
  input  logic [3:0] a3_w,
  input  logic       rf_we_w,
  output logic [1:0] fwd
);
  // youngest producer wins so the operand sees the most recent write
  always_comb fwd = reg_match(rf_we_m, a3_m, rs_e) ? FWD_MEM :
                    reg_match(rf_we_w, a3_w, rs_e) ? FWD_WB : FWD_REG;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencing, forwarding and data-memory handshake for the 5-stage pipe
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       Rs1_D,
  input  logic [3:0]       Rs2_D,
  input  logic [3:0]       Rs1_E,
  input  logic [3:0]       Rs2_E,
  input  logic [3:0]       A3_E,
  input  logic             RF_WE_E,
  input  logic             WBSelect_E,
  input  logic             BranchTaken_E,
  input  logic [3:0]       A3_M,
  input  logic             RF_WE_M,
  input  logic             MemReq_M,
  input  logic [3:0]       A3_W,
  input  logic             RF_WE_W,
  input  logic             MemAck,
  output logic             MemReq_o,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Stall_E,
  output logic             Stall_M,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic             Flush_W,
  output logic [1:0]       FwdA_E,
  output logic [1:0]       FwdB_E,
  output logic             Fault,
  output logic [CNT_W-1:0] StallCnt
);
  localparam int WC_W = $clog2(TIMEOUT) + 1;
  state_t state, state_nx;
  logic [WC_W-1:0] wait_cnt, wait_nx;
  logic fault_q;
  logic [CNT_W-1:0] stall_cnt;
  logic mem_miss, load_use;
  logic [1:0] fwd_a, fwd_b;
  assign mem_miss = MemReq_M && !MemAck;
  assign load_use = RF_WE_E && WBSelect_E && (A3_E == Rs1_D || A3_E == Rs2_D);
  pipe_fwd_sel u_fwd_a (
    .rs_e(Rs1_E), .a3_m(A3_M), .rf_we_m(RF_WE_M), .a3_w(A3_W), .rf_we_w(RF_WE_W), .fwd(fwd_a)
  );
  pipe_fwd_sel u_fwd_b (
    .rs_e(Rs2_E), .a3_m(A3_M), .rf_we_m(RF_WE_M), .a3_w(A3_W), .rf_we_w(RF_WE_W), .fwd(fwd_b)
  );
  // state, wait counter, sticky fault and saturating stall counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      wait_cnt  <= '0;
      fault_q   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      fault_q  <= fault_q || (state_nx == ERR);
      if (Stall_F && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
  // next state: an ack on the last wait cycle still returns to RUN
  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    case (state)
      RUN: if (mem_miss) begin
        state_nx = MEMWAIT;
        wait_nx  = WC_W'(1);
      end
      MEMWAIT: if (MemAck) begin
        state_nx = RUN;
        wait_nx  = '0;
      end else begin
        wait_nx  = wait_cnt + 1'b1;
        state_nx = (wait_cnt == WC_W'(TIMEOUT - 1)) ? ERR : MEMWAIT;
      end
      ERR: state_nx = ERR;
      default: state_nx = RUN;
    endcase
  end
  // Mealy hazard outputs; reset forces bubbles everywhere and no stalls
  always_comb begin
    {Stall_F, Stall_D, Stall_E, Stall_M} = 4'b0000;
    {Flush_D, Flush_E, Flush_W} = 3'b000;
    if (RST) {Flush_D, Flush_E, Flush_W} = 3'b111;
    else case (state)
      RUN: begin
        if (mem_miss) begin
          {Stall_F, Stall_D, Stall_E, Stall_M} = 4'b1111;
          Flush_W = 1'b1;
        end else if (BranchTaken_E) {Flush_D, Flush_E} = 2'b11;
        else if (load_use) begin
          {Stall_F, Stall_D} = 2'b11;
          Flush_E = 1'b1;
        end
      end
      MEMWAIT: if (!MemAck) begin
        {Stall_F, Stall_D, Stall_E, Stall_M} = 4'b1111;
        Flush_W = 1'b1;
      end
      default: begin
        {Stall_F, Stall_D, Stall_E, Stall_M} = 4'b1111;
        Flush_W = 1'b1;
      end
    endcase
  end
  // request, forwarding and status outputs
  always_comb begin
    MemReq_o = !RST && (state != ERR) && MemReq_M;
    FwdA_E   = RST ? FWD_REG : fwd_a;
    FwdB_E   = RST ? FWD_REG : fwd_b;
    Fault    = fault_q && !RST;
    StallCnt = stall_cnt;
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks of the hazard controller against a behavioural model
module tb_pipe_hazard_ctrl;
  localparam int TIMEOUT = 4;
  localparam int CNT_W = 6;
  localparam int CNT_MAX = 63;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [3:0] Rs1_D = 0, Rs2_D = 0, Rs1_E = 0, Rs2_E = 0, A3_E = 0, A3_M = 0, A3_W = 0;
  logic RF_WE_E = 0, WBSelect_E = 0, BranchTaken_E = 0, RF_WE_M = 0, MemReq_M = 0, RF_WE_W = 0, MemAck = 0;
  logic MemReq_o, Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W, Fault;
  logic [1:0] FwdA_E, FwdB_E;
  logic [CNT_W-1:0] StallCnt;
  int total = 0;
  int bad = 0;
  int m_wait = 0;
  bit m_fault = 0;
  int m_cnt = 0;

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .A3_E(A3_E), .RF_WE_E(RF_WE_E), .WBSelect_E(WBSelect_E), .BranchTaken_E(BranchTaken_E),
    .A3_M(A3_M), .RF_WE_M(RF_WE_M), .MemReq_M(MemReq_M), .A3_W(A3_W), .RF_WE_W(RF_WE_W),
    .MemAck(MemAck), .MemReq_o(MemReq_o), .Stall_F(Stall_F), .Stall_D(Stall_D),
    .Stall_E(Stall_E), .Stall_M(Stall_M), .Flush_D(Flush_D), .Flush_E(Flush_E),
    .Flush_W(Flush_W), .FwdA_E(FwdA_E), .FwdB_E(FwdB_E), .Fault(Fault), .StallCnt(StallCnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [3:0] rs);
    if (RST) return 2'b00;
    if (RF_WE_M && A3_M == rs) return 2'b10;
    if (RF_WE_W && A3_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  // one clock: compare every output with the model, then advance the model across the edge
  task automatic step(input string tag);
    logic [3:0] e_st;
    logic [2:0] e_fl;
    bit miss;
    e_st = 4'b0000;
    e_fl = 3'b000;
    miss = 0;
    #1;
    if (RST) e_fl = 3'b111;
    else if (m_fault) begin e_st = 4'b1111; e_fl = 3'b001; end
    else if ((m_wait > 0 || MemReq_M) && !MemAck) begin e_st = 4'b1111; e_fl = 3'b001; miss = 1; end
    else if (m_wait > 0) e_st = 4'b0000;
    else if (BranchTaken_E) e_fl = 3'b110;
    else if (RF_WE_E && WBSelect_E && (A3_E == Rs1_D || A3_E == Rs2_D)) begin e_st = 4'b1100; e_fl = 3'b010; end
    chk({tag, ".stall"}, {4'b0, Stall_F, Stall_D, Stall_E, Stall_M}, {4'b0, e_st});
    chk({tag, ".flush"}, {5'b0, Flush_D, Flush_E, Flush_W}, {5'b0, e_fl});
    chk({tag, ".memreq"}, {7'b0, MemReq_o}, {7'b0, !RST && !m_fault && MemReq_M});
    chk({tag, ".fwda"}, {6'b0, FwdA_E}, {6'b0, fwd_ref(Rs1_E)});
    chk({tag, ".fwdb"}, {6'b0, FwdB_E}, {6'b0, fwd_ref(Rs2_E)});
    chk({tag, ".fault"}, {7'b0, Fault}, {7'b0, !RST && m_fault});
    chk({tag, ".cnt"}, {2'b0, StallCnt}, 8'(m_cnt));
    @(posedge CLK);
    if (RST) begin
      m_wait = 0; m_fault = 0; m_cnt = 0;
    end else begin
      if (e_st[3] && m_cnt < CNT_MAX) m_cnt++;
      if (!m_fault) begin
        if (miss) begin
          m_wait++;
          if (m_wait == TIMEOUT) m_fault = 1;
        end else m_wait = 0;
      end
    end
    @(negedge CLK);
  endtask

  task automatic clear_inputs();
    {Rs1_D, Rs2_D, Rs1_E, Rs2_E, A3_E, A3_M, A3_W} = '0;
    {RF_WE_E, WBSelect_E, BranchTaken_E, RF_WE_M, MemReq_M, RF_WE_W, MemAck} = '0;
    Rs2_D = 4'd9;
  endtask

  initial begin
    clear_inputs();
    @(negedge CLK);
    step("rst0");
    step("rst1");
    RST = 0;
    step("idle");
    A3_E = 5; RF_WE_E = 1; WBSelect_E = 1; Rs1_D = 5;
    #1 chk("lu_stallf", {7'b0, Stall_F}, 8'd1);
    step("loaduse");
    chk("lu_cnt", {2'b0, StallCnt}, 8'd1);
    BranchTaken_E = 1;
    #1 chk("br_stallf", {7'b0, Stall_F}, 8'd0);
    chk("br_flush", {6'b0, Flush_D, Flush_E}, 8'd3);
    step("branch_lu");
    clear_inputs();
    RST = 1;
    step("rst_pre_mem");
    RST = 0;
    MemReq_M = 1;
    for (int i = 0; i < 3; i++) step("memwait");
    MemAck = 1;
    #1 chk("ack_flushw", {7'b0, Flush_W}, 8'd0);
    step("memack");
    MemReq_M = 0; MemAck = 0;
    #1 chk("mem_run", {7'b0, Stall_F}, 8'd0);
    chk("mem_cnt", {2'b0, StallCnt}, 8'd3);
    step("after_mem");
    MemReq_M = 1;
    for (int i = 0; i < 4; i++) step("tmo");
    chk("tmo_fault", {7'b0, Fault}, 8'd1);
    MemAck = 1;
    for (int i = 0; i < 70; i++) step("err");
    chk("err_sat", {2'b0, StallCnt}, 8'd63);
    chk("err_fault", {7'b0, Fault}, 8'd1);
    RST = 1;
    step("err_rst");
    RST = 0; MemReq_M = 0; MemAck = 0;
    chk("rst_fault", {7'b0, Fault}, 8'd0);
    step("post_rst");
    Rs1_E = 3; A3_M = 3; RF_WE_M = 1; A3_W = 3; RF_WE_W = 1;
    #1 chk("fwd_mem", {6'b0, FwdA_E}, 8'd2);
    step("fwd1");
    RF_WE_M = 0;
    #1 chk("fwd_wb", {6'b0, FwdA_E}, 8'd1);
    step("fwd2");
    RF_WE_W = 0;
    #1 chk("fwd_reg", {6'b0, FwdA_E}, 8'd0);
    step("fwd3");
    Rs2_E = 7; A3_W = 7; RF_WE_W = 1;
    step("fwdb");
    clear_inputs();
    MemReq_M = 1;
    step("rmw0");
    step("rmw1");
    RST = 1;
    #1 chk("rmw_flush", {5'b0, Flush_D, Flush_E, Flush_W}, 8'd7);
    chk("rmw_stall", {4'b0, Stall_F, Stall_D, Stall_E, Stall_M}, 8'd0);
    step("rmw_rst");
    RST = 0; MemReq_M = 0;
    #1 chk("rmw_run", {7'b0, Stall_F}, 8'd0);
    step("rmw_after");
    for (int i = 0; i < 500; i++) begin
      RST = ($urandom_range(0, 39) == 0);
      Rs1_D = 4'($urandom_range(0, 3)); Rs2_D = 4'($urandom_range(0, 3));
      Rs1_E = 4'($urandom_range(0, 3)); Rs2_E = 4'($urandom_range(0, 3));
      A3_E = 4'($urandom_range(0, 3)); A3_M = 4'($urandom_range(0, 3)); A3_W = 4'($urandom_range(0, 3));
      RF_WE_E = 1'($urandom_range(0, 1)); WBSelect_E = 1'($urandom_range(0, 1));
      RF_WE_M = 1'($urandom_range(0, 1)); RF_WE_W = 1'($urandom_range(0, 1));
      BranchTaken_E = ($urandom_range(0, 4) == 0);
      MemReq_M = ($urandom_range(0, 2) == 0);
      MemAck = 1'($urandom_range(0, 1));
      step("rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
